mips_encode: RTL and testbench
==============================

# mips_encode

Sequential MIPS instruction encoder: the inverse of the control decoder. It accepts field-level instruction requests (kind, ALU function, registers, immediate) over a valid/ready handshake and packs each legal request into a 32-bit MIPS word. Each word is tagged with a word address from an internal counter and held in a 2-entry output FIFO. It sits between the self-test/boot program sequencer and the instruction-memory write port. Requests with no legal encoding are dropped and counted.

## Interface
- BASE_ADDR, 32'h0040_0000 — byte address loaded into the address counter at reset; bits [1:0] are ignored.
- clk  in  1  — clock, rising edge.
- rst  in  1  — reset, asynchronous, active-high.
- req_valid  in  1  — request present.
- req_ready  out  1  — encoder can accept a request.
- req_kind  in  3  — request class: KIND_RTYPE, KIND_SHIFT, KIND_ITYPE, KIND_LUI, KIND_REGIMM, KIND_JR, KIND_JALR, KIND_SYSCALL.
- req_alu  in  4  — ALU function, using the same ALU_* codes the decoder emits.
- req_uns  in  1  — select the unsigned variant (ADDU/SUBU/SLTU/ADDIU/SLTIU).
- req_link  in  1  — link variant for REGIMM (BLTZAL/BGEZAL).
- req_rs, req_rt, req_rd, req_shamt  in  5 each  — register and shift fields.
- req_imm  in  16  — immediate field.
- addr_load  in  1  — load the address counter from addr_in.
- addr_in  in  30  — word address to load.
- instr_valid  out  1  — FIFO head is valid.
- instr_ready  in  1  — consumer accepts the FIFO head.
- instr  out  32  — encoded word at the FIFO head.
- instr_addr  out  30  — word address of the FIFO head.
- err  out  1  — one-cycle pulse: the previously accepted request was illegal.
- err_count  out  8  — saturating count of illegal requests.

## Operation
- Accept: req_valid && req_ready. req_ready = (fifo_count != 2). There is no combinational path from instr_ready to req_ready.
- Encoding, mapped exactly as the decoder inverts it:
  - RTYPE: op=0, funct from req_alu ∈ {ADD, SUB, AND, OR, XOR, NOR, SLT, SLLV, SRLV, SRAV}. req_uns selects ADDU/SUBU/SLTU. shamt=0.
  - SHIFT: op=0, req_alu ∈ {SLL, SRL, SRA}, rs=0.
  - ITYPE: ADD→ADDI/ADDIU, SLT→SLTI/SLTIU, AND→ANDI, OR→ORI, XOR→XORI.
  - LUI: rs=0.
  - REGIMM: op=1, SLT→BLTZ, SUB→BGEZ. req_link ORs 0x10 into the rt field.
  - JR: rt=rd=0. JALR: rt=0, rd=req_rd. SYSCALL: word = 32'h0000_000C.
- Illegal request: any req_alu/req_kind pair outside the list above. Also illegal: req_uns set on AND/OR/XOR/NOR/shift, or req_link set outside REGIMM. An illegal request is still accepted (handshake completes) but is not enqueued, and the address counter does not advance.
- Address counter (30 bits):
  - Each enqueued word takes the current value; the counter then increments by 1.
  - 30'h3FFF_FFFF wraps to 0.
  - addr_load in the same cycle as a legal accept: that word gets addr_in, and the counter becomes addr_in+1.
  - addr_load alone: counter = addr_in.
- FIFO: 2 entries of {instr, instr_addr}. Pop on instr_valid && instr_ready. Push and pop in the same cycle at count 2 cannot occur, because req_ready is 0. At count 1, push and pop together keep the count at 1.
- err_count saturates at 8'hFF.

## Timing
- Encode is registered. A request accepted in cycle N appears at the FIFO head in cycle N+1 if the FIFO was empty. Otherwise it appears after the entries ahead of it are popped.
- err asserts in cycle N+1 for exactly one cycle. err_count updates in the same cycle.
- Reset values:
  - instr_valid=0, instr=0, instr_addr=0, err=0, err_count=0.
  - FIFO empty; req_ready=1 once rst deasserts.
  - Address counter = BASE_ADDR[31:2].
- Reset mid-stream: FIFO contents and any staged request are discarded immediately and asynchronously; nothing is emitted after rst deasserts.
- instr and instr_addr are stable while instr_valid && !instr_ready.

## Structure
- Shared package mips_encode_pkg:
  - req_kind enum.
  - OP_* and OP0_*/OP1_* encodings.
  - ALU_* codes, kept in the same package the decoder uses.
  - Packed FIFO entry struct.
- Sub-module mips_encode_fifo: 2-entry synchronous FIFO with count, push, pop, full, empty, and async-high reset.
- Encoding is one combinational always_comb function in the top level; the staging, address, and error registers are also in the top level.

## Test plan
- RTYPE ADD, rs=1, rt=2, rd=3, uns=0, after reset with BASE_ADDR default → cycle+1: instr=32'h0022_1820, instr_addr=30'h0010_0000.
- ITYPE ADD, uns=1, rs=0, rt=8, imm=16'hFFFF → instr=32'h2408_FFFF. A second request then gets instr_addr = previous+1.
- REGIMM SUB, link=1, rs=4, imm=16'h0003 → instr=32'h0491_0003. SYSCALL → 32'h0000_000C.
- ITYPE NOR → not enqueued, err pulses one cycle, err_count=1, address unchanged. Then 260 illegal requests → err_count holds 8'hFF.
- instr_ready=0 with 3 back-to-back requests → req_ready drops after 2 accepts, and the head stays stable. Releasing instr_ready drains the words in order with consecutive addresses.
- addr_load with addr_in=30'h3FFF_FFFF together with a legal accept → that word gets 30'h3FFF_FFFF and the next word gets 0. Asserting rst while 2 entries are queued → instr_valid=0 immediately and the counter returns to BASE_ADDR[31:2].

Source files
------------

// File: rtl/mips_encode_pkg.sv
// Shared encodings for the MIPS instruction encoder: request kinds, ALU codes
// (same values the control decoder emits), opcode/funct/REGIMM-rt fields and
// the FIFO entry layout.
package mips_encode_pkg;

  typedef enum logic [2:0] {
    KIND_RTYPE   = 3'd0,
    KIND_SHIFT   = 3'd1,
    KIND_ITYPE   = 3'd2,
    KIND_LUI     = 3'd3,
    KIND_REGIMM  = 3'd4,
    KIND_JR      = 3'd5,
    KIND_JALR    = 3'd6,
    KIND_SYSCALL = 3'd7
  } req_kind_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLLV = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_SRAV = 4'd12;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  // SPECIAL funct field
  localparam logic [5:0] OP0_SLL     = 6'h00;
  localparam logic [5:0] OP0_SRL     = 6'h02;
  localparam logic [5:0] OP0_SRA     = 6'h03;
  localparam logic [5:0] OP0_SLLV    = 6'h04;
  localparam logic [5:0] OP0_SRLV    = 6'h06;
  localparam logic [5:0] OP0_SRAV    = 6'h07;
  localparam logic [5:0] OP0_JR      = 6'h08;
  localparam logic [5:0] OP0_JALR    = 6'h09;
  localparam logic [5:0] OP0_SYSCALL = 6'h0C;
  localparam logic [5:0] OP0_ADD     = 6'h20;
  localparam logic [5:0] OP0_ADDU    = 6'h21;
  localparam logic [5:0] OP0_SUB     = 6'h22;
  localparam logic [5:0] OP0_SUBU    = 6'h23;
  localparam logic [5:0] OP0_AND     = 6'h24;
  localparam logic [5:0] OP0_OR      = 6'h25;
  localparam logic [5:0] OP0_XOR     = 6'h26;
  localparam logic [5:0] OP0_NOR     = 6'h27;
  localparam logic [5:0] OP0_SLT     = 6'h2A;
  localparam logic [5:0] OP0_SLTU    = 6'h2B;

  // REGIMM rt field
  localparam logic [4:0] OP1_BLTZ = 5'h00;
  localparam logic [4:0] OP1_BGEZ = 5'h01;
  localparam logic [4:0] OP1_LINK = 5'h10;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] addr;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/mips_encode_fifo.sv
// Two-entry synchronous FIFO holding encoded words with their addresses.
module mips_encode_fifo
  import mips_encode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [1:0]         count,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset discards all contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (do_push && !do_pop) begin
        count <= count + 2'd1;
      end else if (do_pop && !do_push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/mips_encode.sv
// MIPS instruction encoder: packs field-level requests into 32-bit words,
// tags them with a word address and queues them for the imem write port.
module mips_encode
  import mips_encode_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [3:0]  req_alu,
  input  logic        req_uns,
  input  logic        req_link,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [15:0] req_imm,
  input  logic        addr_load,
  input  logic [29:0] addr_in,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [29:0] instr_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  req_kind_t   kind;
  logic [31:0] word;
  logic        legal;
  logic [5:0]  funct;
  logic [5:0]  op;
  logic [4:0]  rt_field;
  logic        bad_uns;
  logic        bad_link;

  logic        accept;
  logic        push;
  logic        pop;
  logic [29:0] addr_cnt;
  logic [29:0] push_addr;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic [1:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;

  assign kind     = req_kind_t'(req_kind);
  assign bad_uns  = req_uns && (req_alu inside {ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
                                                ALU_SLL, ALU_SRL, ALU_SRA,
                                                ALU_SLLV, ALU_SRLV, ALU_SRAV});
  assign bad_link = req_link && (kind != KIND_REGIMM);

  // Field-level request to instruction word, plus legality
  always_comb begin
    word     = '0;
    legal    = 1'b1;
    funct    = '0;
    op       = '0;
    rt_field = '0;
    case (kind)
      KIND_RTYPE: begin
        case (req_alu)
          ALU_ADD:  funct = req_uns ? OP0_ADDU : OP0_ADD;
          ALU_SUB:  funct = req_uns ? OP0_SUBU : OP0_SUB;
          ALU_SLT:  funct = req_uns ? OP0_SLTU : OP0_SLT;
          ALU_AND:  funct = OP0_AND;
          ALU_OR:   funct = OP0_OR;
          ALU_XOR:  funct = OP0_XOR;
          ALU_NOR:  funct = OP0_NOR;
          ALU_SLLV: funct = OP0_SLLV;
          ALU_SRLV: funct = OP0_SRLV;
          ALU_SRAV: funct = OP0_SRAV;
          default:  legal = 1'b0;
        endcase
        word = {OP_SPECIAL, req_rs, req_rt, req_rd, 5'd0, funct};
      end
      KIND_SHIFT: begin
        case (req_alu)
          ALU_SLL: funct = OP0_SLL;
          ALU_SRL: funct = OP0_SRL;
          ALU_SRA: funct = OP0_SRA;
          default: legal = 1'b0;
        endcase
        word = {OP_SPECIAL, 5'd0, req_rt, req_rd, req_shamt, funct};
      end
      KIND_ITYPE: begin
        case (req_alu)
          ALU_ADD: op = req_uns ? OP_ADDIU : OP_ADDI;
          ALU_SLT: op = req_uns ? OP_SLTIU : OP_SLTI;
          ALU_AND: op = OP_ANDI;
          ALU_OR:  op = OP_ORI;
          ALU_XOR: op = OP_XORI;
          default: legal = 1'b0;
        endcase
        word = {op, req_rs, req_rt, req_imm};
      end
      KIND_LUI: begin
        word = {OP_LUI, 5'd0, req_rt, req_imm};
      end
      KIND_REGIMM: begin
        case (req_alu)
          ALU_SLT: rt_field = OP1_BLTZ;
          ALU_SUB: rt_field = OP1_BGEZ;
          default: legal = 1'b0;
        endcase
        if (req_link) begin
          rt_field = rt_field | OP1_LINK;
        end
        word = {OP_REGIMM, req_rs, rt_field, req_imm};
      end
      KIND_JR: begin
        word = {OP_SPECIAL, req_rs, 5'd0, 5'd0, 5'd0, OP0_JR};
      end
      KIND_JALR: begin
        word = {OP_SPECIAL, req_rs, 5'd0, req_rd, 5'd0, OP0_JALR};
      end
      KIND_SYSCALL: begin
        word = {26'd0, OP0_SYSCALL};
      end
    endcase
    if (bad_uns || bad_link) begin
      legal = 1'b0;
    end
  end

  assign req_ready  = (fifo_count != 2'd2);
  assign accept     = req_valid && req_ready;
  assign push       = accept && legal && !fifo_full;
  assign pop        = instr_valid && instr_ready;
  assign push_addr  = addr_load ? addr_in : addr_cnt;
  assign push_entry = '{instr: word, addr: push_addr};

  // Word address counter; a load coinciding with a push tags that word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= BASE_WORD;
    end else if (push) begin
      addr_cnt <= push_addr + 30'd1;
    end else if (addr_load) begin
      addr_cnt <= addr_in;
    end
  end

  // Illegal-request pulse and saturating counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  mips_encode_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = head.instr;
  assign instr_addr  = head.addr;

endmodule

// File: tb/tb_mips_encode.sv
// Randomized and directed checks of mips_encode against a queue-based model.
module tb_mips_encode;
  import mips_encode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [3:0]  req_alu;
  logic        req_uns;
  logic        req_link;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [15:0] req_imm;
  logic        addr_load;
  logic [29:0] addr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [29:0] instr_addr;
  logic        err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  mips_encode #(.BASE_ADDR(32'h0040_0000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_alu(req_alu), .req_uns(req_uns), .req_link(req_link),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_imm(req_imm), .addr_load(addr_load), .addr_in(addr_in),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_addr(instr_addr), .err(err), .err_count(err_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [31:0] w;
    logic [29:0] a;
  } exp_t;
  exp_t        q[$];
  logic [29:0] m_cnt;
  int          m_ecnt;
  bit          m_err;

  task automatic model_reset();
    q.delete();
    m_cnt  = 30'h0010_0000;
    m_ecnt = 0;
    m_err  = 0;
  endtask

  // MIPS encoding from the instruction-set tables, computed with shifts/adds
  function automatic void ref_enc(input int kind, input int alu, input bit uns, input bit link,
                                  input int rs, input int rt, input int rd, input int sh,
                                  input int imm, output bit ok, output logic [31:0] w);
    int f;
    int op;
    int code;
    ok = 1;
    f  = -1;
    op = -1;
    code = -1;
    w  = '0;
    if (uns && (alu == ALU_AND || alu == ALU_OR || alu == ALU_XOR || alu == ALU_NOR ||
                alu == ALU_SLL || alu == ALU_SRL || alu == ALU_SRA ||
                alu == ALU_SLLV || alu == ALU_SRLV || alu == ALU_SRAV)) ok = 0;
    if (link && kind != KIND_REGIMM) ok = 0;
    case (kind)
      KIND_RTYPE: begin
        if (alu == ALU_ADD) f = 32 + int'(uns);
        if (alu == ALU_SUB) f = 34 + int'(uns);
        if (alu == ALU_AND) f = 36;
        if (alu == ALU_OR)  f = 37;
        if (alu == ALU_XOR) f = 38;
        if (alu == ALU_NOR) f = 39;
        if (alu == ALU_SLT) f = 42 + int'(uns);
        if (alu == ALU_SLLV) f = 4;
        if (alu == ALU_SRLV) f = 6;
        if (alu == ALU_SRAV) f = 7;
        if (f < 0) ok = 0;
        else w = (rs << 21) | (rt << 16) | (rd << 11) | f;
      end
      KIND_SHIFT: begin
        if (alu == ALU_SLL) f = 0;
        if (alu == ALU_SRL) f = 2;
        if (alu == ALU_SRA) f = 3;
        if (f < 0) ok = 0;
        else w = (rt << 16) | (rd << 11) | (sh << 6) | f;
      end
      KIND_ITYPE: begin
        if (alu == ALU_ADD) op = 8 + int'(uns);
        if (alu == ALU_SLT) op = 10 + int'(uns);
        if (alu == ALU_AND) op = 12;
        if (alu == ALU_OR)  op = 13;
        if (alu == ALU_XOR) op = 14;
        if (op < 0) ok = 0;
        else w = (op << 26) | (rs << 21) | (rt << 16) | imm;
      end
      KIND_LUI:  w = (15 << 26) | (rt << 16) | imm;
      KIND_REGIMM: begin
        if (alu == ALU_SLT) code = 0;
        if (alu == ALU_SUB) code = 1;
        if (code < 0) ok = 0;
        else w = (1 << 26) | (rs << 21) | ((code + (link ? 16 : 0)) << 16) | imm;
      end
      KIND_JR:   w = (rs << 21) | 8;
      KIND_JALR: w = (rs << 21) | (rd << 11) | 9;
      default:   w = 32'd12;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "/rdy"}, 32'(req_ready), 32'(q.size() != 2));
    check({tag, "/valid"}, 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({tag, "/instr"}, instr, q[0].w);
      check({tag, "/addr"}, 32'(instr_addr), 32'(q[0].a));
    end
    check({tag, "/err"}, 32'(err), 32'(m_err));
    check({tag, "/errcnt"}, 32'(err_count), 32'(m_ecnt));
  endtask

  // Advance model and DUT one clock, then check at the falling edge
  task automatic step(input string tag);
    bit acc, pop, ok;
    logic [31:0] w;
    logic [29:0] a;
    acc = req_valid && (q.size() < 2);
    pop = (q.size() > 0) && instr_ready;
    ref_enc(int'(req_kind), int'(req_alu), req_uns, req_link, int'(req_rs), int'(req_rt),
            int'(req_rd), int'(req_shamt), int'(req_imm), ok, w);
    if (pop) void'(q.pop_front());
    m_err = acc && !ok;
    if (acc && ok) begin
      a = addr_load ? addr_in : m_cnt;
      q.push_back('{w: w, a: a});
      m_cnt = a + 30'd1;
    end else if (addr_load) begin
      m_cnt = addr_in;
    end
    if (acc && !ok && m_ecnt < 255) m_ecnt++;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic req(input string tag, input req_kind_t k, input logic [3:0] alu,
                     input logic uns, input logic link, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                     input logic [15:0] imm);
    req_valid = 1'b1;
    req_kind  = k;
    req_alu   = alu;
    req_uns   = uns;
    req_link  = link;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_shamt = sh;
    req_imm   = imm;
    step(tag);
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    step(tag);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_kind = '0; req_alu = '0; req_uns = 0; req_link = 0;
    req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0; req_imm = '0;
    addr_load = 0; addr_in = '0; instr_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset/instr", instr, 32'h0);
    check("reset/addr", 32'(instr_addr), 32'h0);
    check_outputs("reset");

    // Basic encodings
    req("rtype_add", KIND_RTYPE, ALU_ADD, 0, 0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
    check("rtype_add_word", instr, 32'h0022_1820);
    check("rtype_add_addr", 32'(instr_addr), 32'h0010_0000);
    req("addiu", KIND_ITYPE, ALU_ADD, 1, 0, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF);
    check("addiu_word", instr, 32'h2408_FFFF);
    check("addiu_addr", 32'(instr_addr), 32'h0010_0001);
    req("bgezal", KIND_REGIMM, ALU_SUB, 0, 1, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0003);
    check("bgezal_word", instr, 32'h0491_0003);
    req("syscall", KIND_SYSCALL, ALU_ADD, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    check("syscall_word", instr, 32'h0000_000C);
    idle("idle0");

    // Illegal request: dropped, error pulse, address unchanged
    req("nor_itype", KIND_ITYPE, ALU_NOR, 0, 0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1);
    check("nor_err", 32'(err), 32'd1);
    check("nor_errcnt", 32'(err_count), 32'd1);
    idle("err_clear");
    check("err_pulse_end", 32'(err), 32'd0);
    req("after_err", KIND_LUI, ALU_ADD, 0, 0, 5'd0, 5'd9, 5'd0, 5'd0, 16'h1234);
    check("after_err_addr", 32'(instr_addr), 32'h0010_0004);
    for (int i = 0; i < 260; i++) begin
      req("illegal_burst", KIND_SHIFT, ALU_ADD, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    end
    idle("sat");
    check("errcnt_sat", 32'(err_count), 32'hFF);

    // Backpressure: two accepts fill the FIFO, head holds
    instr_ready = 1'b0;
    req("bp0", KIND_RTYPE, ALU_OR, 0, 0, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0);
    req("bp1", KIND_RTYPE, ALU_XOR, 0, 0, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0);
    check("bp_full", 32'(req_ready), 32'd0);
    req("bp2", KIND_JALR, ALU_ADD, 0, 0, 5'd11, 5'd0, 5'd31, 5'd0, 16'h0);
    req("bp2_hold", KIND_JALR, ALU_ADD, 0, 0, 5'd11, 5'd0, 5'd31, 5'd0, 16'h0);
    check("bp_head_stable", instr, 32'h00A6_3825);
    instr_ready = 1'b1;
    req("drain0", KIND_JALR, ALU_ADD, 0, 0, 5'd11, 5'd0, 5'd31, 5'd0, 16'h0);
    idle("drain1");
    idle("drain2");
    idle("drain3");

    // Address load with wrap
    addr_load = 1'b1;
    addr_in   = 30'h3FFF_FFFF;
    req("load_top", KIND_JR, ALU_ADD, 0, 0, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0);
    check("load_top_addr", 32'(instr_addr), 32'h3FFF_FFFF);
    addr_load = 1'b0;
    req("wrap", KIND_SHIFT, ALU_SRA, 0, 0, 5'd0, 5'd3, 5'd4, 5'd17, 16'h0);
    check("wrap_addr", 32'(instr_addr), 32'h0);

    // Reset with two entries queued
    instr_ready = 1'b0;
    req("q0", KIND_RTYPE, ALU_SUB, 1, 0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0);
    req("q1", KIND_RTYPE, ALU_SLT, 1, 0, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(instr_valid), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    check_outputs("post_rst");
    req("post_rst_req", KIND_RTYPE, ALU_NOR, 0, 0, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0);
    check("post_rst_addr", 32'(instr_addr), 32'h0010_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid   = ($urandom_range(0, 9) < 7);
      req_kind    = 3'($urandom_range(0, 7));
      req_alu     = 4'($urandom_range(0, 15));
      req_uns     = ($urandom_range(0, 3) == 0);
      req_link    = ($urandom_range(0, 6) == 0);
      req_rs      = 5'($urandom);
      req_rt      = 5'($urandom);
      req_rd      = 5'($urandom);
      req_shamt   = 5'($urandom);
      req_imm     = 16'($urandom);
      instr_ready = ($urandom_range(0, 9) < 6);
      addr_load   = ($urandom_range(0, 31) == 0);
      addr_in     = 30'($urandom);
      if ($urandom_range(0, 63) == 0) addr_in = 30'h3FFF_FFFF;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
